// File: rtl/moore_seq_gen.sv
// Moore serial frame transmitter: sync preamble, MSB-first payload, idle gap, one-cycle done.
// Optional even-parity bit after the payload when PARITY_EN is defined.
module moore_seq_gen #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1100,
  parameter int                GAP_CYCLES   = 2,
  localparam int               MAX_A        = (SYNC_W > DATA_W) ? SYNC_W : DATA_W,
  localparam int               MAX_B        = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES,
  localparam int               CNT_W        = $clog2(MAX_B) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              op,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_DATA = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
`ifdef PARITY_EN
    , S_PAR = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SYNC_W-1:0] sync_sh;
`ifdef PARITY_EN
  logic              par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      op_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SYNC;
          cnt_d   = '0;
          shreg_d = data_in;
`ifdef PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      S_SYNC: begin
        if (cnt_q == CNT_W'(SYNC_W - 1)) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d = '0;
`ifdef PARITY_EN
          state_d = S_PAR;
`else
          state_d = (GAP_CYCLES == 0) ? S_DONE : S_GAP;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PARITY_EN
      S_PAR: begin
        cnt_d   = '0;
        state_d = (GAP_CYCLES == 0) ? S_DONE : S_GAP;
      end
`endif
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the upcoming state so the first sync bit lands right after the accepting edge.
    sync_sh = SYNC_PATTERN << cnt_d;
    op_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_SYNC: begin
        op_d   = sync_sh[SYNC_W-1];
        busy_d = 1'b1;
      end
      S_DATA: begin
        op_d   = shreg_d[DATA_W-1];
        busy_d = 1'b1;
      end
`ifdef PARITY_EN
      S_PAR: begin
        op_d   = par_d;
        busy_d = 1'b1;
      end
`endif
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: op_d   = 1'b0;
    endcase
  end

  assign op      = op_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Randomized bench for moore_seq_gen; expected bit stream built per frame into a queue.
module tb_moore_seq_gen;
  localparam int         GAP  = 2;
  localparam logic [3:0] SYNC = 4'b1100;
`ifdef PARITY_EN
  localparam int         FLEN = 4 + 8 + 1 + GAP;
`else
  localparam int         FLEN = 4 + 8 + GAP;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       op;
  logic       busy;
  logic       done;
  logic [3:0] bit_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_v;
  int         busy_len;
  int         done_cnt;
  int         det_hits;
  logic [3:0] det_sh;

  moore_seq_gen dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .op      (op),
    .busy    (busy),
    .done    (done),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Entries are {op, busy, done}; a frame ends with DONE and its mandatory IDLE slot.
  task automatic push_frame(input logic [7:0] d);
    logic [3:0] s;
    s = SYNC;
    for (int i = 3; i >= 0; i--) exp_q.push_back({s[i], 2'b10});
    for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 2'b10});
`ifdef PARITY_EN
    exp_q.push_back({^d, 2'b10});
`endif
    repeat (GAP) exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      exp_v = 3'b000;
    end else begin
      if (exp_q.size() == 0 && start) push_frame(data_in);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    end
    #1;
    check("op", 32'(op), 32'(exp_v[2]));
    check("busy", 32'(busy), 32'(exp_v[1]));
    check("done", 32'(done), 32'(exp_v[0]));
    if (busy) busy_len++;
    if (done) done_cnt++;
    det_sh = {det_sh[2:0], op};
    if (det_sh == 4'b1100) det_hits++;
  endtask

  task automatic clear_tally();
    busy_len = 0;
    done_cnt = 0;
    det_hits = 0;
    det_sh   = 4'b0000;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    clear_tally();
    repeat (2) step();
    check("reset_bit_cnt", 32'(bit_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Single frame 8'hA5
    clear_tally();
    data_in = 8'hA5;
    start   = 1'b1;
    step();
    start   = 1'b0;
    data_in = 8'h00;
    repeat (20) step();
    check("a5_busy_len", 32'(busy_len), 32'(FLEN));
    check("a5_done_cnt", 32'(done_cnt), 32'd1);

    // Start pulse mid-DATA must be ignored
    clear_tally();
    data_in = 8'h5A;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    data_in = 8'hFF;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    check("ign_busy_len", 32'(busy_len), 32'(FLEN));
    check("ign_done_cnt", 32'(done_cnt), 32'd1);

    // Start held high: back-to-back frames of 8'h3C
    clear_tally();
    data_in = 8'h3C;
    start   = 1'b1;
    repeat (2 * (FLEN + 2)) step();
    start = 1'b0;
    repeat (FLEN + 4) step();
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // Reset during DATA bit 3, then a clean frame
    data_in = 8'hC3;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    check("abort_bit_cnt", 32'(bit_cnt), 32'd0);
    reset = 1'b0;
    step();
    clear_tally();
    data_in = 8'h96;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    check("clean_busy_len", 32'(busy_len), 32'(FLEN));

    // 1100 detector on the serial stream for payload 8'h0C
    clear_tally();
    data_in = 8'h0C;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    check("det_hits", 32'(det_hits), 32'd2);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      start   = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (FLEN + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
